// File: rtl/cordic_exp.sv
// cordic_exp: e^x for a signed Q8.24 natural-log value, returned as unsigned Q16.16.
// x is split into k*ln2 + r, e^r comes from a hyperbolic rotation-mode CORDIC,
// and the final shift by k applies the 2^k factor. One shared iteration engine
// sits under a small FSM with valid/ready handshakes on both sides.
module cordic_exp #(
    parameter int ITER = 16,
    parameter int FW   = 30
) (
    input  logic        i_clk,
    input  logic        i_arstn,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_data_in,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_data_out,
    output logic        o_ovf
);

    localparam int W  = FW + 4;
    localparam int W2 = 2 * W;
    localparam logic [4:0] ITER_L = 5'(ITER);

    // Constants are written in Q30 and rescaled to the datapath fraction.
    localparam logic signed [63:0] INV_LN2_Q30 = 64'sd1549082005;   // 1/ln2
    localparam logic signed [63:0] LN2_Q30     = 64'sd744261118;    // ln2
    localparam logic signed [63:0] GAIN_Q30    = 64'sd1296540104;   // 1/K_h = 1.2074970678

    localparam logic signed [31:0] SAT_X  = 32'sh0B17_2180;         // ~16*ln2: result >= 2^16
    localparam logic signed [31:0] ZERO_X = 32'shF400_0000;         // -12.0: result rounds to 0

    function automatic logic signed [63:0] q30_to_fw(input logic signed [63:0] v);
        if (FW >= 30) begin
            return v <<< (FW - 30);
        end else begin
            return v >>> (30 - FW);
        end
    endfunction

    // atanh(2^-i) in Q30; from i=11 upward the cubic term is below half an LSB.
    function automatic logic signed [63:0] atanh_q30(input int i);
        logic signed [63:0] v;
        v = 64'sd0;
        case (i)
            1:  v = 64'sd589812981;
            2:  v = 64'sd274247418;
            3:  v = 64'sd134923406;
            4:  v = 64'sd67196451;
            5:  v = 64'sd33565361;
            6:  v = 64'sd16778582;
            7:  v = 64'sd8388779;
            8:  v = 64'sd4194325;
            9:  v = 64'sd2097155;
            10: v = 64'sd1048576;
            default: begin
                if (i >= 11 && i <= 30) begin
                    v = 64'sd1 <<< (30 - i);
                end
            end
        endcase
        return v;
    endfunction

    localparam logic signed [63:0]  LN2_FW  = q30_to_fw(LN2_Q30);
    localparam logic signed [W-1:0] GAIN_FW = W'(q30_to_fw(GAIN_Q30));

    typedef enum logic [2:0] {
        S_IDLE,
        S_RED1,
        S_RED2,
        S_ROT,
        S_SCALE,
        S_OUT
    } state_t;

    state_t state_reg, state_next;
    logic   ready_reg;
    logic   accept;

    logic [31:0]         xin_reg, xin_next;
    logic signed [9:0]   k_reg, k_next;
    logic                sat_reg, sat_next;
    logic                zero_reg, zero_next;
    logic signed [W-1:0] x_reg, x_next;
    logic signed [W-1:0] y_reg, y_next;
    logic signed [W-1:0] z_reg, z_next;
    logic [4:0]          idx_reg, idx_next;
    logic                rep_reg, rep_next;
    logic [31:0]         data_reg, data_next;
    logic                ovf_reg, ovf_next;

    // Range reduction helpers
    logic signed [63:0]  k_prod;
    logic signed [9:0]   k_calc;
    logic signed [63:0]  r_full;

    // Micro-rotation helpers
    logic signed [W-1:0] atanh_tab [0:31];
    logic signed [W-1:0] atanh_cur;
    logic signed [W-1:0] x_shift, y_shift;
    logic signed [W-1:0] x_rot, y_rot, z_rot;
    logic                d_pos;
    logic                rep_pending;
    logic                rot_last;

    // Scaling helpers
    logic signed [W-1:0]  e_sum, e_fix;
    logic signed [W2-1:0] corr_prod;
    logic signed [63:0]   e64;
    logic signed [10:0]   shift_amt, neg_amt;
    logic signed [63:0]   scl_val;
    logic                 scl_big;
    logic                 scl_ovf;

    // Angle table: entries outside 1..ITER are never selected and read as zero.
    for (genvar gi = 0; gi < 32; gi++) begin : g_atanh
        if (gi >= 1 && gi <= ITER) begin : g_used
            assign atanh_tab[gi] = W'(q30_to_fw(atanh_q30(gi)));
        end else begin : g_unused
            assign atanh_tab[gi] = '0;
        end
    end

    assign accept = i_valid && ready_reg;

    // k = floor(x/ln2): Q24 * Q30 product, so the integer part sits above bit 54.
    assign k_prod = 64'($signed(xin_reg)) * INV_LN2_Q30;
    assign k_calc = 10'(k_prod >>> 54);

    // r = x - k*ln2 with x promoted from Q24 to the datapath fraction.
    assign r_full = (64'($signed(xin_reg)) <<< (FW - 24)) - 64'(k_reg) * LN2_FW;

    assign atanh_cur   = atanh_tab[idx_reg];
    assign d_pos       = ~z_reg[W-1];
    assign x_shift     = x_reg >>> idx_reg;
    assign y_shift     = y_reg >>> idx_reg;
    assign x_rot       = d_pos ? (x_reg + y_shift) : (x_reg - y_shift);
    assign y_rot       = d_pos ? (y_reg + x_shift) : (y_reg - x_shift);
    assign z_rot       = d_pos ? (z_reg - atanh_cur) : (z_reg + atanh_cur);
    assign rep_pending = ((idx_reg == 5'd4) || (idx_reg == 5'd13)) && !rep_reg;
    assign rot_last    = (idx_reg == ITER_L) && !rep_pending;

    // x+y = e^(r - z_res); the leftover angle is tiny, so a first-order
    // correction e*(1+z_res) removes the truncation error of the last index.
    assign e_sum     = x_reg + y_reg;
    assign corr_prod = W2'(e_sum) * W2'(z_reg);
    assign e_fix     = e_sum + W'(corr_prod >>> FW);
    assign e64       = 64'(e_fix);
    assign shift_amt = 11'(k_reg) - 11'(FW - 16);
    assign neg_amt   = -shift_amt;

    // Apply 2^k and drop to 16 fractional bits, rounding half-up on right shifts.
    always_comb begin
        scl_val = '0;
        scl_big = 1'b0;
        if (shift_amt >= 11'sd0) begin
            if (shift_amt > 11'sd31) begin
                scl_big = 1'b1;
            end else begin
                scl_val = e64 <<< shift_amt[4:0];
            end
        end else if (neg_amt <= 11'sd62) begin
            scl_val = (e64 + (64'sd1 <<< (neg_amt[5:0] - 6'd1))) >>> neg_amt[5:0];
        end
    end

    assign scl_ovf = scl_big || (scl_val[63:32] != 32'd0);

    // FSM state register; reset discards any in-flight operation.
    always_ff @(posedge i_clk) begin
        if (!i_arstn) begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == S_IDLE);
        end
    end

    // FSM next-state and output-valid decode.
    always_comb begin
        state_next = state_reg;
        o_valid    = 1'b0;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_RED1;
            S_RED1:  state_next = S_RED2;
            S_RED2:  state_next = S_ROT;
            S_ROT:   if (rot_last) state_next = S_SCALE;
            S_SCALE: state_next = S_OUT;
            S_OUT: begin
                o_valid = 1'b1;
                if (i_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath next values per state.
    always_comb begin
        xin_next  = xin_reg;
        k_next    = k_reg;
        sat_next  = sat_reg;
        zero_next = zero_reg;
        x_next    = x_reg;
        y_next    = y_reg;
        z_next    = z_reg;
        idx_next  = idx_reg;
        rep_next  = rep_reg;
        data_next = data_reg;
        ovf_next  = ovf_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) xin_next = i_data_in;
            end
            S_RED1: begin
                k_next    = k_calc;
                sat_next  = ($signed(xin_reg) >= SAT_X);
                zero_next = ($signed(xin_reg) < ZERO_X);
            end
            S_RED2: begin
                x_next   = GAIN_FW;
                y_next   = '0;
                z_next   = W'(r_full);
                idx_next = 5'd1;
                rep_next = 1'b0;
            end
            S_ROT: begin
                x_next = x_rot;
                y_next = y_rot;
                z_next = z_rot;
                if (rep_pending) begin
                    rep_next = 1'b1;
                end else begin
                    rep_next = 1'b0;
                    idx_next = idx_reg + 5'd1;
                end
            end
            S_SCALE: begin
                if (zero_reg) begin
                    data_next = 32'h0000_0000;
                    ovf_next  = 1'b0;
                end else if (sat_reg || scl_ovf) begin
                    data_next = 32'hFFFF_FFFF;
                    ovf_next  = 1'b1;
                end else begin
                    data_next = scl_val[31:0];
                    ovf_next  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_arstn) begin
            xin_reg  <= '0;
            k_reg    <= '0;
            sat_reg  <= 1'b0;
            zero_reg <= 1'b0;
            x_reg    <= '0;
            y_reg    <= '0;
            z_reg    <= '0;
            idx_reg  <= 5'd1;
            rep_reg  <= 1'b0;
            data_reg <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            xin_reg  <= xin_next;
            k_reg    <= k_next;
            sat_reg  <= sat_next;
            zero_reg <= zero_next;
            x_reg    <= x_next;
            y_reg    <= y_next;
            z_reg    <= z_next;
            idx_reg  <= idx_next;
            rep_reg  <= rep_next;
            data_reg <= data_next;
            ovf_reg  <= ovf_next;
        end
    end

    assign o_ready    = ready_reg;
    assign o_data_out = data_reg;
    assign o_ovf      = ovf_reg;

endmodule

// File: tb/tb_cordic_exp.sv
// tb_cordic_exp: directed bench for cordic_exp with an expected-result queue.
module tb_cordic_exp;

    logic        i_clk = 1'b0;
    logic        i_arstn;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data_in;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data_out;
    logic        o_ovf;

    always #5 i_clk = ~i_clk;

    cordic_exp dut (
        .i_clk      (i_clk),
        .i_arstn    (i_arstn),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data_in  (i_data_in),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data_out (o_data_out),
        .o_ovf      (o_ovf)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] data;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    localparam int NOPS = 8;
    localparam logic [31:0] OP_X   [NOPS] = '{32'h0000_0000, 32'h0100_0000, 32'h00B1_7218, 32'hFF00_0000,
                                              32'h0A00_0000, 32'h0C00_0000, 32'hF000_0000, 32'h0B17_2180};
    localparam logic [31:0] OP_EXP [NOPS] = '{32'h0001_0000, 32'h0002_B7E1, 32'h0002_0000, 32'h0000_5E2D,
                                              32'h560A_773E, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    localparam logic        OP_OVF [NOPS] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Saturated and zero results must be exact; others allow 2 LSB or 2^-20 relative.
    task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp, input logic exact);
        longint diff;
        longint tol;
        logic   ok;
        diff = longint'(obs) - longint'(exp);
        if (diff < 0) diff = -diff;
        tol = longint'(exp >> 20);
        if (tol < 2) tol = 2;
        if (exact) tol = 0;
        ok = (diff <= tol);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h tol=%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] exp_d, input logic exp_o);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("send_ready", 32'(o_ready), 32'd1);
        i_valid   = 1'b1;
        i_data_in = x;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        sb_q.push_back('{x, exp_d, exp_o});
    endtask

    // Wait for the result, compare against the queue head, optionally stall
    // downstream for 'hold' cycles (with an intruding request), then handshake.
    task automatic collect(input int hold);
        int          lat;
        exp_t        e;
        logic [31:0] held_d;
        logic        held_o;
        lat = 0;
        do begin
            @(posedge i_clk);
            #1;
            lat++;
        end while (!o_valid && lat < 60);
        check("latency", 32'(lat), 32'd21);
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL sb_depth observed=%0d expected=>0", sb_q.size());
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_near("data", o_data_out, e.data, e.ovf || (e.data == 32'd0));
            check("ovf", 32'(o_ovf), 32'(e.ovf));
            $display("txn x=0x%08h data=0x%08h ovf=%0b exp=0x%08h lat=%0d", e.x, o_data_out, o_ovf, e.data, lat);
        end
        held_d = o_data_out;
        held_o = o_ovf;
        for (int j = 0; j < hold; j++) begin
            if (j == 1) begin
                i_valid   = 1'b1;
                i_data_in = 32'h0C00_0000;
            end
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_ready", 32'(o_ready), 32'd0);
            check("bp_data", o_data_out, held_d);
            check("bp_ovf", 32'(o_ovf), 32'(held_o));
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check("post_valid", 32'(o_valid), 32'd0);
        check("post_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        int stale;
        i_arstn   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_data_in = '0;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", o_data_out, 32'd0);
        check("rst_ovf", 32'(o_ovf), 32'd0);
        @(negedge i_clk);
        i_arstn = 1'b1;
        @(posedge i_clk);
        #1;
        check("rel_ready", 32'(o_ready), 32'd1);
        check("rel_valid", 32'(o_valid), 32'd0);

        // Directed values, including saturation and underflow boundaries
        for (int i = 0; i < NOPS; i++) begin
            send(OP_X[i], OP_EXP[i], OP_OVF[i]);
            collect(0);
        end

        // Backpressure, then the next operation must still be correct
        send(32'h0100_0000, 32'h0002_B7E1, 1'b0);
        collect(5);
        send(32'h00B1_7218, 32'h0002_0000, 1'b0);
        collect(0);

        // Reset in the middle of the rotation phase
        send(32'h0100_0000, 32'h0002_B7E1, 1'b0);
        repeat (11) @(posedge i_clk);
        @(negedge i_clk);
        i_arstn = 1'b0;
        @(posedge i_clk);
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        i_arstn = 1'b1;
        sb_q.delete();
        @(posedge i_clk);
        #1;
        check("midrel_ready", 32'(o_ready), 32'd1);
        check("midrel_valid", 32'(o_valid), 32'd0);
        stale = 0;
        for (int j = 0; j < 30; j++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) stale++;
        end
        check("no_stale", 32'(stale), 32'd0);
        send(32'h0000_0000, 32'h0001_0000, 1'b0);
        collect(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_exp.md
Name: cordic_exp

Overview:
- Inverse of the natural-log block: takes a signed fix32_24 natural-log value x and returns e^x as unsigned fix32_16.
- Range reduction: x = k*ln2 + r. e^r is computed by an iterative hyperbolic CORDIC in rotation mode. A final shift by k gives 2^k*e^r.
- Single shared iteration engine under an FSM, with a valid/ready handshake on both sides. Intended for the tail of log-domain datapaths.

Parameters:
- ITER, 16, distinct hyperbolic indices i=1..ITER (legal 12..24). Indices 4 and 13 execute twice.
- FW, 30, fractional bits of internal x/y/z datapath. Signed width FW+4.

Ports:
- i_clk  in  1  clock, rising edge
- i_arstn  in  1  reset, synchronous, active-low
- i_valid  in  1  input request
- o_ready  out  1  block can accept; high only in S_IDLE
- i_data_in  in  32  x, signed fix32_24
- o_valid  out  1  result valid; held until i_ready
- i_ready  in  1  downstream accepts result
- o_data_out  out  32  e^x, unsigned fix32_16
- o_ovf  out  1  result saturated; qualified by o_valid

Behaviour:
- Reset (i_arstn low at a clock edge, any state):
  - FSM goes to S_IDLE.
  - o_valid=0, o_ready=0 during reset, then 1 in the first cycle after release.
  - o_data_out=0, o_ovf=0.
  - Any in-flight operation is discarded.
- Accept: i_valid & o_ready at an edge. The block captures x and moves to S_RED1.
- S_RED1 (1 cycle):
  - k = floor(x * round(2^FW/ln2)), taken after rescale.
  - Flag sat = (x >= 0x0B17_2180), zero = (x < 0xF400_0000, i.e. x < -12.0). Both comparisons are signed.
- S_RED2 (1 cycle):
  - r = x - k*ln2, using ln2 as a FW-fraction constant.
  - x0 = round(1.2074970678*2^FW), y0 = 0, z0 = r.
  - The constant is fixed; it is valid for any legal ITER, with gain error < 2^-24.
- S_ROT (ITER+2 cycles for ITER>=13, ITER+1 for ITER<13): one micro-rotation per cycle.
  - d = +1 if z >= 0, else -1.
  - x' = x + d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atanh(2^-i).
  - atanh values come from a FW-fraction constant table.
  - An index counter steps 1..ITER; a repeat flag re-runs indices 4 and 13 once each.
- S_SCALE (1 cycle):
  - e = x + y, which lies in [1,2) in Q.FW.
  - s = k - (FW-16). If s >= 0, shift left by s; else arithmetic-right-shift by -s with round-half-up.
  - Any overflow beyond 32 bits sets sat.
  - Output selection: zero -> 0x00000000, o_ovf=0; sat -> 0xFFFFFFFF, o_ovf=1; otherwise the shifted value.
- S_OUT:
  - o_valid=1; o_data_out and o_ovf stay stable.
  - On i_ready at an edge, go to S_IDLE; o_valid drops the next cycle.
- Latency: constant. o_valid rises 21 cycles after the accept edge for ITER=16. Saturated and zero cases take the same latency.
- Throughput: at most one result per 22 cycles. There is no accept in the same cycle as the output handshake.
- Backpressure: i_valid while o_ready=0 is ignored. The upstream must hold its request.
- Accuracy: |error| <= 2 LSB of fix32_16, or relative error <= 2^-20, whichever is larger.
- k range: [-18, 16]. All shift amounts fit a 6-bit signed field.

Test Plan:
- Reset then x=0x00000000 -> after 21 cycles o_valid=1, o_data_out=0x00010000 (+/-2), o_ovf=0.
- x=0x01000000 (1.0) -> o_data_out=0x0002B7E1 (+/-2). x=0x00B17218 (ln2) -> 0x00020000 (+/-2).
- Sign and sub-unity cases:
  - x=0xFF000000 (-1.0) -> 0x00005E2D (+/-2).
  - x=0x0A000000 (10.0) -> 0x560A773E within relative 2^-20.
- Boundaries:
  - x=0x0C000000 (12.0) -> 0xFFFFFFFF, o_ovf=1.
  - x=0xF0000000 (-16.0) -> 0x00000000, o_ovf=0.
  - x=0x0B172180 -> saturated, o_ovf=1.
- Backpressure: hold i_ready low 5 cycles with o_valid=1. Required:
  - outputs stay stable;
  - o_ready=0;
  - a new i_valid pulse is not accepted;
  - after i_ready, o_ready=1 on the next cycle and the following x is processed correctly.
- Reset mid-operation: assert i_arstn low at cycle 10 of S_ROT. Required: o_valid=0 and o_ready=1 after release, and no stale result appears. A new x=0 then yields 0x00010000.
